coin_acceptor: RTL

Coin-chute front end that sits directly upstream of the vending machine controller. It synchronises and debounces the two raw coin-sensor lines, classifies each coin, and emits clean single-cycle `io_nickel` / `io_dime` pulses that the controller consumes unchanged. Invalid coins, coins arriving while a vend is in progress, and jammed coins are diverted to reject and jam indications instead.

---
 rtl/coin_pkg.sv | 23 ++
 rtl/coin_sync.sv | 30 +++
 rtl/coin_acceptor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// coin_pkg: shared types and constants for the coin acceptor.
//   state_t          FSM states IDLE / SETTLE / HOLD / JAM
//   NONE..BOTH       sensor pattern codes, encoded {dime, nickel}
//   DEBOUNCE_DEF     default debounce depth (samples)
//   JAM_LIMIT_DEF    default cycles a coin may sit on the sensors before a jam
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2,
    JAM    = 2'd3
  } state_t;

  localparam logic [1:0] NONE   = 2'b00;
  localparam logic [1:0] NICKEL = 2'b01;
  localparam logic [1:0] DIME   = 2'b10;
  localparam logic [1:0] BOTH   = 2'b11;

  localparam int unsigned DEBOUNCE_DEF  = 4;
  localparam int unsigned JAM_LIMIT_DEF = 64;

endpackage

// File: rtl/coin_sync.sv
// coin_sync: two-flop synchroniser for the raw coin-sensor lines.
//   clk      in   sampling clock
//   reset    in   synchronous, active-low; clears both flop stages
//   async_i  in   raw asynchronous sensor bits {dime, nickel}
//   sync_o   out  synchronised copy, two clock edges behind async_i
module coin_sync
  import coin_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] async_i,
  output logic [1:0] sync_o
);

  logic [1:0] meta_q;
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= NONE;
      sync_q <= NONE;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces and classifies coins from two bouncy sensors and
// emits single-cycle accept/reject pulses plus a jam level.
//   clk              in   single clock, rising edge
//   reset            in   synchronous, active-low
//   io_sense_nickel  in   raw nickel-size sensor (asynchronous, bouncy)
//   io_sense_dime    in   raw dime-size sensor (asynchronous, bouncy)
//   io_busy          in   vend in progress; sampled only at the decision edge
//   io_nickel        out  one-cycle pulse, nickel accepted
//   io_dime          out  one-cycle pulse, dime accepted
//   io_reject        out  one-cycle pulse, coin rejected
//   io_jam           out  level, coin stuck on the sensors
//
// state  | meaning
// IDLE   | sensors clear, waiting for a coin
// SETTLE | pattern seen, counting identical samples before deciding
// HOLD   | decision made, waiting for the coin to leave the sensors
// JAM    | coin stayed too long, jam raised until the sensors clear
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE  = DEBOUNCE_DEF,
  parameter int unsigned JAM_LIMIT = JAM_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic io_sense_nickel,
  input  logic io_sense_dime,
  input  logic io_busy,
  output logic io_nickel,
  output logic io_dime,
  output logic io_reject,
  output logic io_jam
);

  localparam int CW = $clog2(JAM_LIMIT + 1);
  localparam logic [CW-1:0] DEB_M1 = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] DEB    = CW'(DEBOUNCE);
  localparam logic [CW-1:0] JAM_M1 = CW'(JAM_LIMIT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [1:0]    sync;
  state_t        state_q;
  logic [1:0]    pat_q;
  logic [CW-1:0] cnt_q, hcnt_q, rcnt_q;
  logic [CW-1:0] cnt_d, hcnt_d, rcnt_d;
  logic          nickel_q, dime_q, reject_q, jam_q;

  coin_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i ({io_sense_dime, io_sense_nickel}),
    .sync_o  (sync)
  );

  // Saturating increments so no counter can wrap back to a small value.
  always_comb begin
    cnt_d  = (cnt_q  == '1) ? cnt_q  : cnt_q  + ONE;
    hcnt_d = (hcnt_q == '1) ? hcnt_q : hcnt_q + ONE;
    rcnt_d = (rcnt_q == '1) ? rcnt_q : rcnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      pat_q    <= NONE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      rcnt_q   <= '0;
      nickel_q <= 1'b0;
      dime_q   <= 1'b0;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      nickel_q <= 1'b0;
      dime_q   <= 1'b0;
      reject_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sync != NONE) begin
            pat_q   <= sync;
            cnt_q   <= ONE;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync == pat_q) begin
            if (cnt_q == DEB_M1) begin
              state_q <= HOLD;
              hcnt_q  <= '0;
              rcnt_q  <= '0;
              cnt_q   <= '0;
              if (io_busy) begin
                reject_q <= 1'b1;
              end else begin
                unique case (pat_q)
                  NICKEL:  nickel_q <= 1'b1;
                  DIME:    dime_q   <= 1'b1;
                  default: reject_q <= 1'b1;
                endcase
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end else if (sync == NONE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            // Pattern changed mid-settle: restart on the new pattern.
            pat_q <= sync;
            cnt_q <= ONE;
          end
        end
        HOLD, JAM: begin
          // Release wins over jam onset when both land on the same edge.
          if ((sync == NONE) && (rcnt_d == DEB)) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            hcnt_q  <= '0;
            jam_q   <= 1'b0;
          end else begin
            rcnt_q <= (sync == NONE) ? rcnt_d : '0;
            if (state_q == HOLD) begin
              if (hcnt_q == JAM_M1) begin
                state_q <= JAM;
                jam_q   <= 1'b1;
              end else begin
                hcnt_q <= hcnt_d;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_nickel = nickel_q;
  assign io_dime   = dime_q;
  assign io_reject = reject_q;
  assign io_jam    = jam_q;

endmodule
